// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared I2C definitions: target FSM state encodings and the
//               WM8731 codec bus constants used by both initiator and target.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  // Target FSM states; the encoding is exported on state_info for debug.
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_WRITE     = 4'd3,
    S_WRITE_ACK = 4'd4,
    S_READ      = 4'd5,
    S_READ_ACK  = 4'd6,
    S_IGNORE    = 4'd7
  } state_t;

  // WM8731 7-bit bus address and the control registers the initiator programs.
  localparam logic [6:0] WM8731_ADDR            = 7'b0011010;
  localparam logic [6:0] WM8731_REG_RESET       = 7'b0001111;
  localparam logic [6:0] WM8731_REG_SAMPLE_CTRL = 7'b0001000;

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_line_sync
// Description : Synchronizes scl/sda into the clk domain and produces
//               single-cycle scl rise/fall and bus START/STOP pulses.
// Ports       : clk, reset        - system clock, async active-high reset
//               scl, sda          - raw bus pins (asynchronous)
//               sda_s             - synchronized sda level
//               scl_rise/scl_fall - synced scl edge pulses
//               start_det/stop_det- START / STOP condition pulses
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_s;

  // Flops reset to 1 (idle bus level) so leaving reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s &  scl_prev;
  // Qualified on the current synced scl level only, so a START that lands
  // together with an scl rise is still recognised.
  assign start_det =  scl_s &  sda_prev & ~sda_s;
  assign stop_det  =  scl_s & ~sda_prev &  sda_s;

endmodule
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target
// Description : I2C target (responder) for the codec control bus. Matches a
//               7-bit address, ACKs, delivers written bytes and serves read
//               bytes through a one-pulse byte handshake.
// Ports       : clk, reset  - system clock, async active-high reset
//               scl, sda    - I2C bus (sda open-drain: drives 0 or z)
//               tx_byte     - next read byte, loaded on the scl fall after
//                             tx_req
//               tx_req      - one-cycle request for the next tx_byte
//               rx_byte     - last byte received in a write
//               rx_valid    - one-cycle pulse when rx_byte updates
//               rx_first    - with rx_valid, first data byte after address
//               busy        - addressed transaction in progress
//               state_info  - current FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] PERIPH_ADDR = WM8731_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_byte,
  output logic       tx_req,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       busy,
  output logic [3:0] state_info
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t     state, state_nx;
  logic [3:0] bit_cnt, bit_cnt_nx;
  logic [7:0] shreg, shreg_nx;
  logic [7:0] rx_byte_nx;
  logic       rw, rw_nx;
  logic       ack_on, ack_on_nx;     // ACK phase in progress
  logic       drive_low, drive_low_nx;
  logic       busy_nx, first_pend, first_pend_nx;
  logic       rx_valid_nx, rx_first_nx, tx_req_nx;
  logic [7:0] shifted;

  assign sda        = drive_low ? 1'b0 : 1'bz;
  assign state_info = state;
  assign shifted    = {shreg[6:0], sda_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      rw         <= 1'b0;
      ack_on     <= 1'b0;
      drive_low  <= 1'b0;
      busy       <= 1'b0;
      first_pend <= 1'b0;
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      tx_req     <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_cnt_nx;
      shreg      <= shreg_nx;
      rx_byte    <= rx_byte_nx;
      rw         <= rw_nx;
      ack_on     <= ack_on_nx;
      drive_low  <= drive_low_nx;
      busy       <= busy_nx;
      first_pend <= first_pend_nx;
      rx_valid   <= rx_valid_nx;
      rx_first   <= rx_first_nx;
      tx_req     <= tx_req_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    bit_cnt_nx    = bit_cnt;
    shreg_nx      = shreg;
    rx_byte_nx    = rx_byte;
    rw_nx         = rw;
    ack_on_nx     = ack_on;
    drive_low_nx  = drive_low;
    busy_nx       = busy;
    first_pend_nx = first_pend;
    rx_valid_nx   = 1'b0;
    rx_first_nx   = 1'b0;
    tx_req_nx     = 1'b0;

    // Bus conditions take priority; any scl edge in the same cycle is dropped.
    if (stop_det) begin
      state_nx     = S_IDLE;
      bit_cnt_nx   = '0;
      ack_on_nx    = 1'b0;
      drive_low_nx = 1'b0;
      busy_nx      = 1'b0;
    end else if (start_det) begin
      state_nx     = S_ADDR;
      bit_cnt_nx   = '0;
      ack_on_nx    = 1'b0;
      drive_low_nx = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          drive_low_nx = 1'b0;
        end
        S_ADDR: begin
          if (scl_rise) begin
            shreg_nx   = shifted;
            bit_cnt_nx = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_nx = '0;
              rw_nx      = sda_s;
              ack_on_nx  = 1'b0;
              if (shifted[7:1] == PERIPH_ADDR) begin
                state_nx      = S_ADDR_ACK;
                busy_nx       = 1'b1;
                first_pend_nx = 1'b1;
              end else begin
                state_nx = S_IGNORE;
                busy_nx  = 1'b0;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          // First fall starts the ACK, the second ends it and begins data.
          if (scl_fall) begin
            if (!ack_on) begin
              ack_on_nx    = 1'b1;
              drive_low_nx = 1'b1;
            end else begin
              ack_on_nx  = 1'b0;
              bit_cnt_nx = '0;
              if (rw) begin
                shreg_nx     = tx_byte;
                drive_low_nx = ~tx_byte[7];
                state_nx     = S_READ;
              end else begin
                drive_low_nx = 1'b0;
                state_nx     = S_WRITE;
              end
            end
          end else if (scl_rise && ack_on && rw) begin
            tx_req_nx = 1'b1;
          end
        end
        S_WRITE: begin
          if (scl_rise) begin
            shreg_nx   = shifted;
            bit_cnt_nx = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_nx    = '0;
              rx_byte_nx    = shifted;
              rx_valid_nx   = 1'b1;
              rx_first_nx   = first_pend;
              first_pend_nx = 1'b0;
              ack_on_nx     = 1'b0;
              state_nx      = S_WRITE_ACK;
            end
          end
        end
        S_WRITE_ACK: begin
          if (scl_fall) begin
            if (!ack_on) begin
              ack_on_nx    = 1'b1;
              drive_low_nx = 1'b1;
            end else begin
              ack_on_nx    = 1'b0;
              drive_low_nx = 1'b0;
              state_nx     = S_WRITE;
            end
          end
        end
        S_READ: begin
          // bit_cnt counts bits sampled by the initiator; bit 7 is already on
          // the bus when this state is entered.
          if (scl_rise) begin
            bit_cnt_nx = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              bit_cnt_nx   = '0;
              drive_low_nx = 1'b0;
              ack_on_nx    = 1'b0;
              state_nx     = S_READ_ACK;
            end else begin
              shreg_nx     = {shreg[6:0], 1'b0};
              drive_low_nx = ~shreg[6];
            end
          end
        end
        S_READ_ACK: begin
          if (scl_rise && !ack_on) begin
            if (!sda_s) begin
              ack_on_nx = 1'b1;
              tx_req_nx = 1'b1;
            end else begin
              state_nx = S_IGNORE;
            end
          end else if (scl_fall && ack_on) begin
            ack_on_nx    = 1'b0;
            bit_cnt_nx   = '0;
            shreg_nx     = tx_byte;
            drive_low_nx = ~tx_byte[7];
            state_nx     = S_READ;
          end
        end
        S_IGNORE: begin
          drive_low_nx = 1'b0;
        end
        default: begin
          state_nx     = S_IDLE;
          drive_low_nx = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_target
// Description : Self-checking bench for i2c_target: a bit-level initiator
//               model, a table of write transactions, and hand-written read,
//               repeated-START, reset and minimum-phase sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_low;          // initiator pulling sda low
  wire        sda_bus;
  logic [7:0] tx_byte;
  logic       tx_req, rx_valid, rx_first, busy;
  logic [7:0] rx_byte;
  logic [3:0] state_info;

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clk = ~clk;

  i2c_target #(.PERIPH_ADDR(7'b0011010), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .scl        (scl),
    .sda        (sda_bus),
    .tx_byte    (tx_byte),
    .tx_req     (tx_req),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_first   (rx_first),
    .busy       (busy),
    .state_info (state_info)
  );

  int tests = 0;
  int fails = 0;
  int lo_clk = 8;
  int hi_clk = 8;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- bus monitor / tx_byte provider ----------------
  int         rx_cnt, rx_hi, first_hi, req_cnt, req_hi, tx_idx;
  logic       drove;
  logic [7:0] rx_log [8];
  logic       first_log [8];
  logic [7:0] tx_list [4];
  logic       rx_prev, req_prev;

  task automatic clear_mon();
    rx_cnt = 0; rx_hi = 0; first_hi = 0; req_cnt = 0; req_hi = 0;
    tx_idx = 0; drove = 1'b0;
  endtask

  initial begin
    rx_prev  = 1'b0;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        rx_hi++;
        if (!rx_prev && rx_cnt < 8) begin
          rx_log[rx_cnt]    = rx_byte;
          first_log[rx_cnt] = rx_first;
          rx_cnt++;
        end
      end
      if (rx_first) first_hi++;
      rx_prev = rx_valid;
      if (tx_req) begin
        req_hi++;
        if (!req_prev) begin
          tx_byte = tx_list[tx_idx % 4];
          tx_idx++;
          req_cnt++;
        end
      end
      req_prev = tx_req;
      if (sda_bus === 1'b0 && !m_low) drove = 1'b1;
    end
  end

  // ---------------- initiator model ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    scl = 1'b0;
    wait_clk(lo_clk / 2);
    m_low = ~b;
    wait_clk(lo_clk - lo_clk / 2);
    scl = 1'b1;
    wait_clk(hi_clk / 2);
    s = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
    wait_clk(hi_clk - hi_clk / 2);
  endtask

  task automatic do_start();
    m_low = 1'b1;
    wait_clk(hi_clk);
  endtask

  task automatic do_rstart();
    scl = 1'b0;
    wait_clk(lo_clk / 2);
    m_low = 1'b0;
    wait_clk(lo_clk - lo_clk / 2);
    scl = 1'b1;
    wait_clk(hi_clk / 2);
    m_low = 1'b1;
    wait_clk(hi_clk - hi_clk / 2);
  endtask

  task automatic do_stop();
    scl = 1'b0;
    wait_clk(lo_clk / 2);
    m_low = 1'b1;
    wait_clk(lo_clk - lo_clk / 2);
    scl = 1'b1;
    wait_clk(hi_clk / 2);
    m_low = 1'b0;
    wait_clk(hi_clk - hi_clk / 2 + 4);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      b[i] = s;
    end
    bit_cycle(~ack, s);
  endtask

  // ---------------- write transaction table ----------------
  typedef struct {
    logic [7:0] addr;
    int         n;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
    logic [3:0] exp_state;   // state with scl high after the last 9th clock
  } wvec_t;

  wvec_t vecs [4];

  initial begin
    logic       ack;
    logic [7:0] rb, rb2;

    vecs[0] = '{8'h34, 2, 8'h1E, 8'h00, 1'b1, 4'd4};
    vecs[1] = '{8'h36, 2, 8'hAA, 8'h55, 1'b0, 4'd7};
    vecs[2] = '{8'h34, 2, 8'h10, 8'h01, 1'b1, 4'd4};
    vecs[3] = '{8'h34, 1, 8'hFF, 8'h00, 1'b1, 4'd4};

    reset   = 1'b1;
    scl     = 1'b1;
    m_low   = 1'b0;
    tx_byte = 8'h00;
    clear_mon();
    wait_clk(3);
    check("reset_state", state_info, 0);
    check("reset_busy", busy, 0);
    check("reset_rx_byte", rx_byte, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_first", rx_first, 0);
    check("reset_tx_req", tx_req, 0);
    check("reset_sda", (sda_bus === 1'b1) ? 1 : 0, 1);
    reset = 1'b0;
    wait_clk(4);

    // ---- table-driven writes at scl = clk/16 ----
    for (int v = 0; v < 4; v++) begin
      clear_mon();
      do_start();
      write_byte(vecs[v].addr, ack);
      check($sformatf("v%0d_addr_ack", v), ack, vecs[v].exp_ack);
      write_byte(vecs[v].d0, ack);
      check($sformatf("v%0d_d0_ack", v), ack, vecs[v].exp_ack);
      if (vecs[v].n > 1) begin
        write_byte(vecs[v].d1, ack);
        check($sformatf("v%0d_d1_ack", v), ack, vecs[v].exp_ack);
      end
      check($sformatf("v%0d_state", v), state_info, vecs[v].exp_state);
      check($sformatf("v%0d_busy", v), busy, vecs[v].exp_ack);
      do_stop();
      check($sformatf("v%0d_stop_state", v), state_info, 0);
      check($sformatf("v%0d_stop_busy", v), busy, 0);
      check($sformatf("v%0d_rx_cnt", v), rx_cnt, vecs[v].exp_ack ? vecs[v].n : 0);
      check($sformatf("v%0d_rx_width", v), rx_hi, rx_cnt);
      check($sformatf("v%0d_first_cnt", v), first_hi, vecs[v].exp_ack ? 1 : 0);
      check($sformatf("v%0d_drove", v), drove, vecs[v].exp_ack);
      if (vecs[v].exp_ack) begin
        check($sformatf("v%0d_rx0", v), rx_log[0], vecs[v].d0);
        check($sformatf("v%0d_first0", v), first_log[0], 1);
        if (vecs[v].n > 1) begin
          check($sformatf("v%0d_rx1", v), rx_log[1], vecs[v].d1);
          check($sformatf("v%0d_first1", v), first_log[1], 0);
        end
      end
    end

    // ---- read 0x35: ACK first byte, NACK second ----
    clear_mon();
    tx_list[0] = 8'hA5;
    tx_list[1] = 8'h3C;
    do_start();
    write_byte(8'h35, ack);
    check("rd_addr_ack", ack, 1);
    read_byte(rb, 1'b1);
    read_byte(rb2, 1'b0);
    check("rd_byte0", rb, 8'hA5);
    check("rd_byte1", rb2, 8'h3C);
    check("rd_nack_state", state_info, 7);
    check("rd_req_cnt", req_cnt, 2);
    check("rd_req_width", req_hi, 2);
    check("rd_no_rx", rx_cnt, 0);
    do_stop();
    check("rd_stop_state", state_info, 0);

    // ---- repeated START after one write byte, then read ----
    clear_mon();
    tx_list[0] = 8'h96;
    do_start();
    write_byte(8'h34, ack);
    write_byte(8'h55, ack);
    check("rs_wr_ack", ack, 1);
    do_rstart();
    check("rs_state_addr", state_info, 1);
    check("rs_busy_kept", busy, 1);
    write_byte(8'h35, ack);
    check("rs_rd_addr_ack", ack, 1);
    read_byte(rb, 1'b0);
    check("rs_rd_byte", rb, 8'h96);
    check("rs_rx_cnt", rx_cnt, 1);
    check("rs_rx0", rx_log[0], 8'h55);
    check("rs_req_cnt", req_cnt, 1);
    do_stop();
    check("rs_stop_state", state_info, 0);

    // ---- reset during the 4th bit of a read byte (target driving 0) ----
    clear_mon();
    tx_list[0] = 8'h00;
    do_start();
    write_byte(8'h35, ack);
    begin
      logic s;
      for (int i = 0; i < 3; i++) bit_cycle(1'b1, s);
    end
    scl = 1'b0;
    wait_clk(lo_clk / 2);
    check("rst_target_driving", (sda_bus === 1'b0) ? 1 : 0, 1);
    reset = 1'b1;
    #1;
    check("rst_sda_released", (sda_bus === 1'b1) ? 1 : 0, 1);
    check("rst_state", state_info, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_byte", rx_byte, 0);
    check("rst_tx_req", tx_req, 0);
    wait_clk(2);
    reset = 1'b0;
    wait_clk(2);
    clear_mon();
    write_byte(8'h34, ack);
    check("rst_nostart_ack", ack, 0);
    check("rst_nostart_state", state_info, 0);
    check("rst_nostart_drove", drove, 0);
    do_stop();

    // ---- 4-clk phases, START concurrent with scl rise mid-write ----
    lo_clk = 4;
    hi_clk = 4;
    clear_mon();
    do_start();
    write_byte(8'h34, ack);
    check("fast_addr_ack", ack, 1);
    write_byte(8'h5A, ack);
    check("fast_d_ack", ack, 1);
    scl = 1'b0;
    m_low = 1'b0;
    wait_clk(lo_clk);
    scl = 1'b1;
    m_low = 1'b1;
    wait_clk(hi_clk);
    check("fast_start_state", state_info, 1);
    write_byte(8'h34, ack);
    check("fast_readdr_ack", ack, 1);
    write_byte(8'hC3, ack);
    check("fast_d2_ack", ack, 1);
    do_stop();
    check("fast_rx_cnt", rx_cnt, 2);
    check("fast_rx0", rx_log[0], 8'h5A);
    check("fast_rx1", rx_log[1], 8'hC3);
    check("fast_first1", first_log[1], 1);
    check("fast_stop_state", state_info, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
